// File: rtl/lf_fir_mac.sv
// lf_fir_mac: low-frequency band FIR engine.
// Walks the coefficient ROM in step with the low-frequency queue's read
// pointer. Each sample/coefficient pair passes through a three-stage
// multiply-accumulate pipeline. One rounded Q15 result is produced per
// complete window.
// Optional feature: define LF_FIR_SAT_EN to saturate the output instead of
// letting it wrap.
module lf_fir_mac #(
    parameter int NUM_TAPS = 1021,
    parameter int ACC_W    = 42
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sequencing,
    input  logic signed [15:0] smpl_in,
    output logic        [9:0]  coeff_addr,
    input  logic signed [15:0] coeff_in,
    output logic signed [15:0] smpl_out,
    output logic               out_vld,
    output logic               abort
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_DONE,
        S_WAIT,
        S_ABORT
    } state_e;

    localparam logic        [9:0]       LAST_TAP = 10'(NUM_TAPS - 1);
    localparam logic signed [ACC_W-1:0] RND      = ACC_W'(1 << 14);
    localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'(32'sh3FFF_FFFF);
    localparam logic signed [ACC_W-1:0] SAT_LO   = ~SAT_HI;  // -0x4000_0000

    state_e                   state_q, state_d;
    logic        [9:0]        tap_q, tap_d;
    logic        [1:0]        drain_q, drain_d;
    logic                     issue, acc_clr, flush, res_ld;

    logic                     iss_q;       // tap issued last cycle: ROM/RAM data valid now
    logic                     s1_vld_q, s2_vld_q;
    logic signed [15:0]       s1_smpl_q, s1_coef_q;
    logic signed [31:0]       prod_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  rounded;
    logic signed [15:0]       result;
    logic signed [15:0]       smpl_out_q;
    logic                     out_vld_q, abort_q;
    logic                     unused_rnd;

    assign coeff_addr = tap_q;
    assign smpl_out   = smpl_out_q;
    assign out_vld    = out_vld_q;
    assign abort      = abort_q;

    // FSM state, tap counter and drain counter registers.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tap_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            drain_q <= drain_d;
        end
    end

    // Next-state logic: window tracking, tap issue and control strobes.
    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        drain_d = drain_q;
        issue   = 1'b0;
        acc_clr = 1'b0;
        flush   = 1'b0;
        res_ld  = 1'b0;
        case (state_q)
            S_IDLE: begin
                tap_d = '0;
                if (sequencing) begin
                    // Tap 0 is already addressed, so it issues in this cycle.
                    issue   = 1'b1;
                    acc_clr = 1'b1;
                    if (LAST_TAP == 10'd0) begin
                        drain_d = '0;
                        state_d = S_DRAIN;
                    end else begin
                        tap_d   = 10'd1;
                        state_d = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (sequencing) begin
                    issue = 1'b1;
                    if (tap_q == LAST_TAP) begin
                        drain_d = '0;
                        state_d = S_DRAIN;
                    end else begin
                        tap_d = tap_q + 10'd1;
                    end
                end else begin
                    state_d = S_ABORT;
                end
            end
            S_DRAIN: begin
                // Three cycles carry the last tap through capture, multiply and add.
                if (drain_q == 2'd2) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            S_DONE: begin
                res_ld  = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Extra sequencing cycles are ignored; the counter holds on the last tap.
                if (!sequencing) begin
                    tap_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_ABORT: begin
                flush   = 1'b1;
                tap_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Three-stage MAC pipeline: capture, multiply, sign-extend and accumulate.
    // NOTE: data registers are reset as well so a discarded window leaves no residue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_q     <= 1'b0;
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s1_smpl_q <= '0;
            s1_coef_q <= '0;
            prod_q    <= '0;
            acc_q     <= '0;
        end else begin
            iss_q    <= issue & ~flush;
            s1_vld_q <= iss_q & ~flush;
            s2_vld_q <= s1_vld_q & ~flush;
            if (iss_q) begin
                s1_smpl_q <= smpl_in;
                s1_coef_q <= coeff_in;
            end
            if (s1_vld_q) begin
                prod_q <= s1_smpl_q * s1_coef_q;
            end
            if (acc_clr) begin
                acc_q <= '0;
            end else if (s2_vld_q) begin
                acc_q <= acc_q + {{(ACC_W-32){prod_q[31]}}, prod_q};
            end
        end
    end

    // Round to nearest, then pick the Q15 window of the accumulator.
    assign rounded    = acc_q + RND;
    assign unused_rnd = ^{rounded[ACC_W-1:31], rounded[14:0]};

`ifdef LF_FIR_SAT_EN
    // Clamp results that do not fit in a signed 16-bit output.
    always_comb begin
        if (rounded > SAT_HI) begin
            result = 16'sh7FFF;
        end else if (rounded < SAT_LO) begin
            result = -16'sh8000;
        end else begin
            result = rounded[30:15];
        end
    end
`else
    // Raw bit slice: out-of-range results wrap.
    always_comb begin
        result = rounded[30:15];
    end
`endif

    // Output registers: result held between windows, one-cycle strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smpl_out_q <= '0;
            out_vld_q  <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            out_vld_q <= res_ld;
            abort_q   <= (state_q == S_ABORT);
            if (res_ld) begin
                smpl_out_q <= result;
            end
        end
    end

endmodule

// File: tb/tb_lf_fir_mac.sv
// tb_lf_fir_mac: self-checking bench for lf_fir_mac.
// Models the coefficient ROM and the queue RAM, then drives windows of
// several lengths. Results and pulse timing are compared with a plain
// arithmetic reference computed in the bench.
module tb_lf_fir_mac;

    localparam int NT = 1021;

    logic               clk = 1'b0;
    logic               rst;
    logic               sequencing;
    logic signed [15:0] smpl_in  = '0;
    logic signed [15:0] coeff_in = '0;
    logic        [9:0]  coeff_addr;
    logic signed [15:0] smpl_out;
    logic               out_vld;
    logic               abort;

    logic signed [15:0] coeff_mem [NT];
    logic signed [15:0] samp_mem  [2048];
    int                 ptr = 0;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;
    int vld_cnt, vld_edge, abt_cnt, abt_edge;
    logic signed [15:0] exp_out;

    always #5 clk = ~clk;

    lf_fir_mac dut (
        .clk        (clk),
        .rst        (rst),
        .sequencing (sequencing),
        .smpl_in    (smpl_in),
        .coeff_addr (coeff_addr),
        .coeff_in   (coeff_in),
        .smpl_out   (smpl_out),
        .out_vld    (out_vld),
        .abort      (abort)
    );

    // Synchronous coefficient ROM.
    always @(posedge clk) coeff_in <= coeff_mem[coeff_addr];

    // Queue RAM: one sample per sequencing cycle, read pointer rewinds between windows.
    always @(posedge clk) begin
        if (sequencing) begin
            smpl_in <= samp_mem[ptr];
            if (ptr < 2047) ptr <= ptr + 1;
        end else begin
            ptr <= 0;
        end
    end

    // Pulse monitor: records count and edge index of out_vld / abort.
    always @(posedge clk) begin
        edge_n = edge_n + 1;
        #1;
        if (out_vld) begin
            vld_cnt  = vld_cnt + 1;
            vld_edge = edge_n;
        end
        if (abort) begin
            abt_cnt  = abt_cnt + 1;
            abt_edge = edge_n;
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    // Reference: full-precision dot product, round, then Q15 slice or clamp.
    function automatic logic signed [15:0] golden();
        longint     acc = 0;
        longint     rnd;
        logic [63:0] r;
        for (int i = 0; i < NT; i++) acc += longint'(samp_mem[i]) * longint'(coeff_mem[i]);
        rnd = acc + 64'sd16384;
`ifdef LF_FIR_SAT_EN
        if (rnd > 64'sh3FFF_FFFF) return 16'sh7FFF;
        if (rnd < -64'sh4000_0000) return -16'sh8000;
`endif
        r = rnd;
        return r[30:15];
    endfunction

    task automatic fill_random();
        for (int i = 0; i < NT; i++) coeff_mem[i] = 16'($urandom);
        for (int i = 0; i < 2048; i++) samp_mem[i] = 16'($urandom);
    endtask

    // Drive one window of len sequencing cycles; rst_at > 0 pulses reset at that offset.
    task automatic run_window(input string tag, input int len, input int rst_at);
        int  t0;
        bit  was_reset = 1'b0;
        vld_cnt = 0; abt_cnt = 0; vld_edge = -1; abt_edge = -1;
        @(negedge clk);
        sequencing = 1'b1;
        @(posedge clk);
        #1 t0 = edge_n;
        for (int i = 1; i < len; i++) begin
            @(negedge clk);
            if (rst_at > 0 && i == rst_at) begin
                rst        = 1'b1;
                sequencing = 1'b0;
                was_reset  = 1'b1;
                break;
            end
            if (i == 1050) check({tag, "_addr_hold"}, coeff_addr, NT - 1);
        end
        if (was_reset) begin
            @(negedge clk);
            rst = 1'b0;
            check({tag, "_rst_out"},  smpl_out,   0);
            check({tag, "_rst_vld"},  out_vld,    0);
            check({tag, "_rst_abt"},  abort,      0);
            check({tag, "_rst_addr"}, coeff_addr, 0);
            exp_out = '0;
        end else begin
            @(negedge clk);
            sequencing = 1'b0;
        end
        repeat (30) @(negedge clk);
        if (was_reset) begin
            check({tag, "_vld_cnt"}, vld_cnt, 0);
            check({tag, "_abt_cnt"}, abt_cnt, 0);
        end else if (len < NT) begin
            check({tag, "_vld_cnt"},  vld_cnt, 0);
            check({tag, "_abt_cnt"},  abt_cnt, 1);
            check({tag, "_abt_time"}, abt_edge - t0, len + 1);
        end else begin
            exp_out = golden();
            check({tag, "_vld_cnt"},  vld_cnt, 1);
            check({tag, "_vld_time"}, vld_edge - t0, NT + 3);
            check({tag, "_abt_cnt"},  abt_cnt, 0);
        end
        check({tag, "_out"},  smpl_out,   exp_out);
        check({tag, "_idle_addr"}, coeff_addr, 0);
    endtask

    initial begin
        rst        = 1'b1;
        sequencing = 1'b0;
        exp_out    = '0;
        for (int i = 0; i < NT; i++) coeff_mem[i] = '0;
        for (int i = 0; i < 2048; i++) samp_mem[i] = '0;
        repeat (3) @(negedge clk);
        check("reset_out",  smpl_out,   0);
        check("reset_vld",  out_vld,    0);
        check("reset_abt",  abort,      0);
        check("reset_addr", coeff_addr, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Impulse response.
        fill_random();
        for (int i = 0; i < NT; i++) coeff_mem[i] = '0;
        coeff_mem[0] = 16'sh4000;
        samp_mem[0]  = 16'sh2000;
        run_window("impulse", NT, 0);
        check("impulse_val", smpl_out, 16'sh1000);

        // Negative DC.
        for (int i = 0; i < NT; i++) coeff_mem[i] = 16'sh0020;
        for (int i = 0; i < 2048; i++) samp_mem[i] = -16'sd1;
        run_window("negdc", NT, 0);
        check("negdc_val", smpl_out, -16'sd1);

        // Full-scale saturation / wrap.
        for (int i = 0; i < NT; i++) coeff_mem[i] = 16'sh7FFF;
        for (int i = 0; i < 2048; i++) samp_mem[i] = 16'sh7FFF;
        run_window("sat", NT, 0);
`ifdef LF_FIR_SAT_EN
        check("sat_val", smpl_out, 16'sh7FFF);
`endif

        // Short window must abort and keep the previous result.
        fill_random();
        run_window("short", 500, 0);

        // Long window: single result, counter held until sequencing falls.
        fill_random();
        run_window("long", 1100, 0);

        // Reset mid-window, then a clean window.
        fill_random();
        run_window("rstmid", NT, 300);
        run_window("after_rst", NT, 0);

        // Random full windows.
        for (int k = 0; k < 2; k++) begin
            fill_random();
            run_window("random", NT, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
